inst_fetch_queue: RTL and testbench

//  Parametrised successor of the single-request fetch stage: prefetches sequential instructions over the

---
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 tb/tb_inst_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Sequential instruction prefetcher: keeps up to MAX_OUT requests in flight on the
// req/addr_ok/data_ok bus and buffers {pc,inst} in a DEPTH-entry FIFO for decode.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        ready_i,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic            run_q;
  logic            accept, push, pop, empty;
  logic [CW:0]     credit_used;

  assign empty       = (count_q == '0);
  // Owed responses hold a FIFO slot, so a returning word always has room.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
  assign inst_req    = run_q && !redirect && (outst_q < MAX_C) && (credit_used < DEPTH_C);
  assign inst_addr   = fetch_pc_q;
  assign accept      = inst_req && inst_addr_ok;
  assign valid_o     = !empty && !redirect;
  assign pop         = valid_o && ready_i;
  assign push        = inst_data_ok && !redirect && (disc_q == '0);
  assign busy_o      = (disc_q != '0);
  assign pc_o        = empty ? '0 : mem_q[rd_ptr_q].pc;
  assign inst_o      = empty ? '0 : mem_q[rd_ptr_q].inst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      outst_d    = outst_q - CW'(inst_data_ok);
      // Every response still owed belongs to the old stream; already-marked
      // discards are part of outstanding, so the total owed is the new discard.
      disc_d     = outst_q - CW'(inst_data_ok);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   resp_pc_d  = resp_pc_q + 32'd4;
      outst_d = outst_q + CW'(accept) - CW'(inst_data_ok);
      if (inst_data_ok && (disc_q != '0)) disc_d = disc_q - 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      run_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      run_q      <= 1'b1;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: resp_pc_q, inst: inst_rdata};
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    inst_data_ok |-> (outst_q != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: the bench plays the instruction bus and
// checks every cycle against a queue-based model of the fetch stream.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        ready_i;
  logic        busy_o;

  inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .valid_o(valid_o),
    .pc_o(pc_o), .inst_o(inst_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents and the ordered list of owed bus responses.
  logic [31:0] fq_pc[$];
  logic [31:0] fq_inst[$];
  logic [31:0] owed_addr[$];
  bit          owed_drop[$];
  logic [31:0] m_fetch, m_resp;
  bit          m_run;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13572468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq_pc.delete(); fq_inst.delete(); owed_addr.delete(); owed_drop.delete();
    m_fetch = RESET_PC; m_resp = RESET_PC; m_run = 0;
  endtask

  // One bus cycle: drive inputs after negedge, check outputs, advance model at posedge.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit aok,
                      input bit dok_want, input bit rdy);
    bit          dok, e_req, e_valid, e_busy, d;
    logic [31:0] a;
    dok = dok_want && (owed_addr.size() > 0);
    redirect     = rd;
    redirect_pc  = rpc;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? mem_word(owed_addr[0]) : 32'h0;
    ready_i      = rdy;
    #1;
    e_req   = m_run && !rd && (owed_addr.size() < MAX_OUT) &&
              (fq_pc.size() + owed_addr.size() < DEPTH);
    e_valid = (fq_pc.size() > 0) && !rd;
    e_busy  = 0;
    foreach (owed_drop[i]) if (owed_drop[i]) e_busy = 1;
    chk("inst_req",  {31'b0, inst_req}, {31'b0, e_req});
    chk("inst_addr", inst_addr, m_fetch);
    chk("valid_o",   {31'b0, valid_o},  {31'b0, e_valid});
    chk("busy_o",    {31'b0, busy_o},   {31'b0, e_busy});
    chk("pc_o",      pc_o,   (fq_pc.size() > 0) ? fq_pc[0]   : 32'h0);
    chk("inst_o",    inst_o, (fq_pc.size() > 0) ? fq_inst[0] : 32'h0);
    @(posedge clk);
    if (rd) begin
      if (dok) begin a = owed_addr.pop_front(); d = owed_drop.pop_front(); end
      foreach (owed_drop[i]) owed_drop[i] = 1;
      fq_pc.delete(); fq_inst.delete();
      m_fetch = rpc; m_resp = rpc;
    end else begin
      if (e_valid && rdy) begin a = fq_pc.pop_front(); a = fq_inst.pop_front(); end
      if (dok) begin
        a = owed_addr.pop_front();
        d = owed_drop.pop_front();
        if (!d) begin
          fq_pc.push_back(m_resp); fq_inst.push_back(mem_word(a));
          m_resp = m_resp + 32'd4;
        end
      end
      if (e_req && aok) begin
        owed_addr.push_back(m_fetch); owed_drop.push_back(0);
        m_fetch = m_fetch + 32'd4;
      end
    end
    m_run = 1;
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"},   {31'b0, inst_req}, 32'h0);
    chk({tag, "_addr"},  inst_addr, RESET_PC);
    chk({tag, "_valid"}, {31'b0, valid_o},  32'h0);
    chk({tag, "_busy"},  {31'b0, busy_o},   32'h0);
    chk({tag, "_pc"},    pc_o, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset_checks("rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; redirect = 0; redirect_pc = 0; inst_addr_ok = 0;
    inst_rdata = 0; inst_data_ok = 0; ready_i = 0;
    model_reset();
    #1;
    reset_checks("por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Streaming: addr_ok always, data_ok next cycle, decode always ready.
    repeat (12) step(0, 0, 1, 1, 1);

    // Decode stalls: FIFO fills, issue stops.
    repeat (10) step(0, 0, 1, 1, 0);
    chk("t2_req_low", {31'b0, inst_req}, 32'h0);
    chk("t2_full_valid", {31'b0, valid_o}, 32'h1);
    repeat (6) step(0, 0, 1, 1, 1);

    // Responses withheld: two accepts then hold at the third address.
    do_reset();
    repeat (5) step(0, 0, 1, 0, 1);
    chk("t3_req_low", {31'b0, inst_req}, 32'h0);
    chk("t3_addr_hold", inst_addr, 32'hbfc00008);

    // Redirect with two owed responses: both dropped, new stream from target.
    step(1, 32'h80001000, 1, 0, 1);
    chk("t4_busy", {31'b0, busy_o}, 32'h1);
    repeat (6) step(0, 0, 1, 1, 0);
    chk("t4_valid", {31'b0, valid_o}, 32'h1);
    chk("t4_head_pc", pc_o, 32'h80001000);

    // Redirect with a same-cycle response: that response is dropped too.
    for (int i = 0; i < 20 && (owed_addr.size() > 0 || fq_pc.size() > 0); i++)
      step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 1, 0, 1);
    step(1, 32'h90000000, 0, 1, 1);
    chk("t5_busy", {31'b0, busy_o}, 32'h1);
    chk("t5_empty", {31'b0, valid_o}, 32'h0);
    step(0, 0, 0, 1, 1);
    chk("t5_busy_clear", {31'b0, busy_o}, 32'h0);
    chk("t5_no_push", {31'b0, valid_o}, 32'h0);

    // Random traffic including redirects.
    for (int i = 0; i < 400; i++)
      step(($urandom % 16) == 0, $urandom & 32'hffff_fffc, $urandom % 2,
           ($urandom % 3) != 0, ($urandom % 4) != 0);

    // Address wrap past 0xfffffffc.
    step(1, 32'hfffffff8, 1, 1, 1);
    for (int i = 0; i < 20 && m_fetch != 32'h0; i++) step(0, 0, 1, 1, 1);
    chk("t6_wrap", inst_addr, 32'h0);
    repeat (4) step(0, 0, 1, 1, 1);

    // Asynchronous reset in the middle of a burst.
    repeat (4) step(0, 0, 1, 1, 0);
    chk("t6_pre_valid", {31'b0, valid_o}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    reset_checks("async");
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (10) step(0, 0, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
